// File: rtl/data_mem_if.sv
// Bus bundle for the data memory: shared address, write port and
// combinational read port.
interface data_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              sig_mem_write;
  logic              sig_mem_read;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data_out;

  // Requester side: drives enables, address and write data.
  modport master (
    output sig_mem_write,
    output sig_mem_read,
    output addr,
    output write_data,
    input  read_data_out
  );

  // Memory side: consumes the request, returns read data.
  modport slave (
    input  sig_mem_write,
    input  sig_mem_read,
    input  addr,
    input  write_data,
    output read_data_out
  );
endinterface

// File: rtl/data_mem.sv
// Small register-file style data memory.
// Synchronous write, zero-latency combinational read gated by the read
// enable, and an asynchronous reset that reloads a fixed init table.
module data_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic        clk,
  input logic        rst,
  data_mem_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Reset image: word 0 = 69, word 2 = 9, everything else zero.
  function automatic logic [DATA_W-1:0] init_word(input int idx);
    case (idx)
      0:       init_word = DATA_W'(69);
      2:       init_word = DATA_W'(9);
      default: init_word = '0;
    endcase
  endfunction

  // Next-state of the array: hold every word, overwrite the addressed one on a write.
  always_comb begin
    // NOTE: the whole array gets its hold value first so no path leaves a word unassigned (no latch).
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (bus.sig_mem_write) begin
      mem_d[bus.addr] = bus.write_data;
    end
  end

  // Storage register: async reload of the init table, otherwise take the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is reset on purpose; the reset contents are a functional table, and it is only 8 flops-words.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_word(i);
      end
    end else begin
      // NOTE: non-blocking so every word updates from pre-edge values, giving old-data on same-cycle read/write.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read port reads stored state only (no write bypass) and is not gated by reset.
  assign bus.read_data_out = bus.sig_mem_read ? mem_q[bus.addr] : '0;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus pushes expected read data,
// a monitor pops and compares against the read port.
module tb_data_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic clk;
  logic rst;

  data_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  string             name_q[$];
  logic [DATA_W-1:0] val_q[$];

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: whenever an expectation is queued, compare against the read port.
  initial begin
    string             n;
    logic [DATA_W-1:0] v;
    forever begin
      wait (val_q.size() != 0);
      n = name_q.pop_front();
      v = val_q.pop_front();
      check(n, bus.read_data_out, v);
    end
  end

  // Let inputs settle, queue an expectation, and wait (bounded) for the monitor.
  task automatic expect_rd(input string name, input logic [DATA_W-1:0] val);
    #1;
    name_q.push_back(name);
    val_q.push_back(val);
    for (int i = 0; i < 5 && val_q.size() != 0; i++) #1;
    if (val_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: monitor timeout, queue depth %0d expected 0", name, val_q.size());
      name_q.delete();
      val_q.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    bus.sig_mem_write = wr;
    bus.sig_mem_read  = rd;
    bus.addr          = a;
    bus.write_data    = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 16'd0);
    #3;
    // Reset state and read path during reset
    expect_rd("rst_rd_off", 16'd0);
    drive(1'b0, 1'b1, 3'd0, 16'd0);
    expect_rd("rst_rd_a0", 16'd69);
    // Writes ignored while in reset
    drive(1'b1, 1'b1, 3'd0, 16'd123);
    tick();
    tick();
    expect_rd("rst_wr_ignored_a0", 16'd69);
    drive(1'b0, 1'b0, 3'd0, 16'd0);
    #10;
    rst = 1'b0;

    // Init table readback
    drive(1'b0, 1'b1, 3'd0, 16'd0);
    expect_rd("init_a0", 16'd69);
    drive(1'b0, 1'b1, 3'd2, 16'd0);
    expect_rd("init_a2", 16'd9);
    drive(1'b0, 1'b1, 3'd5, 16'd0);
    expect_rd("init_a5", 16'd0);

    // Write-only then read back
    drive(1'b1, 1'b0, 3'd6, 16'd55);
    expect_rd("wr_only_rd_zero", 16'd0);
    tick();
    expect_rd("wr_only_rd_zero_after", 16'd0);
    drive(1'b0, 1'b1, 3'd6, 16'd0);
    expect_rd("rd_a6_55", 16'd55);

    // Same-address read/write: old data before edge, new after
    drive(1'b1, 1'b1, 3'd0, 16'd55);
    expect_rd("rw_same_before", 16'd69);
    tick();
    expect_rd("rw_same_after", 16'd55);
    drive(1'b0, 1'b0, 3'd0, 16'd0);

    // Both enables low, then read
    expect_rd("idle_zero", 16'd0);
    drive(1'b0, 1'b1, 3'd0, 16'd0);
    expect_rd("idle_then_rd_a0", 16'd55);

    // No write enable: edges and between-edge input churn change nothing
    drive(1'b0, 1'b0, 3'd0, 16'hBEEF);
    tick();
    drive(1'b0, 1'b0, 3'd6, 16'h1234);
    tick();
    drive(1'b0, 1'b1, 3'd0, 16'h5555);
    expect_rd("nowr_a0_hold", 16'd55);
    drive(1'b0, 1'b1, 3'd6, 16'h5555);
    expect_rd("nowr_a6_hold", 16'd55);

    // Async reset mid-cycle discards written data
    drive(1'b1, 1'b0, 3'd6, 16'd77);
    tick();
    drive(1'b0, 1'b1, 3'd6, 16'd0);
    expect_rd("pre_rst_a6_77", 16'd77);
    #20;
    rst = 1'b1;
    expect_rd("async_rst_a6", 16'd0);
    drive(1'b0, 1'b1, 3'd0, 16'd0);
    expect_rd("async_rst_a0", 16'd69);
    drive(1'b1, 1'b1, 3'd6, 16'd999);
    tick();
    tick();
    tick();
    expect_rd("rst_hold_a6", 16'd0);
    drive(1'b1, 1'b1, 3'd0, 16'd999);
    tick();
    expect_rd("rst_hold_a0", 16'd69);
    drive(1'b0, 1'b0, 3'd0, 16'd0);
    #20;
    rst = 1'b0;

    // Address sweep: first write lands on the first edge after reset release
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 1'b0, ADDR_W'(a), DATA_W'(a * 3 + 1));
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 16'd0);
    begin
      logic [DATA_W-1:0] sweep_exp [8] = '{16'd1, 16'd4, 16'd7, 16'd10,
                                           16'd13, 16'd16, 16'd19, 16'd22};
      for (int a = 0; a < 8; a++) begin
        drive(1'b0, 1'b1, ADDR_W'(a), 16'd0);
        expect_rd($sformatf("sweep_a%0d", a), sweep_exp[a]);
      end
    end

    #10;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 3, address width in bits; depth SHALL be 2**ADDR_W (8 words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sig_mem_write  input  1  write enable, sampled on rising clk.
REQ-006 sig_mem_read  input  1  read enable, combinational.
REQ-007 addr  input  ADDR_W  word address, shared by read and write.
REQ-008 write_data  input  DATA_W  data to store.
REQ-009 read_data_out  output  DATA_W  read data.

Function
REQ-010 Storage SHALL be 2**ADDR_W words of DATA_W bits, addressed by addr with no wrap logic needed (all 3-bit codes valid).
REQ-011 Write: on rising clk with rst=0 and sig_mem_write=1, mem[addr] SHALL become write_data; one-cycle latency, visible to reads after that edge.
REQ-012 With sig_mem_write=0, no word SHALL change on a clock edge.
REQ-013 Read: read_data_out SHALL equal mem[addr] combinationally (zero latency) while sig_mem_read=1.
REQ-014 While sig_mem_read=0, read_data_out SHALL be all zeros.
REQ-015 Read and write both asserted, same addr: read_data_out SHALL show the old word before the clock edge and the newly written word after it (no write-through bypass).
REQ-016 Read and write both asserted, different addresses: both SHALL proceed independently.
REQ-017 Both enables low: memory unchanged, read_data_out = 0.
REQ-018 Enables and addr changes between edges SHALL have no effect on stored contents.

Reset
REQ-019 rst=1 SHALL immediately (without waiting for clk) load the initialization table: mem[0]=16'd69 (0x0045), mem[2]=16'd9 (0x0009), all other words = 0.
REQ-020 While rst=1, writes SHALL be ignored; the table SHALL hold.
REQ-021 While rst=1, read_data_out SHALL follow REQ-013/REQ-014 against the reset table (read path not gated by reset).
REQ-022 Reset asserted mid-operation SHALL discard all previously written data and restore the table.
REQ-023 Deassertion of rst SHALL take effect asynchronously; the first write may occur on the first rising clk with rst=0.

Verification
REQ-024 Pulse rst=1 then 0; read=1, write=0, addr=0 -> read_data_out=69; addr=2 -> 9; addr=5 -> 0.
REQ-025 write=1, read=0, addr=6, write_data=55, one rising clk -> read_data_out=0 during the cycle; then read=1, write=0, addr=6 -> 55.
REQ-026 write=1, read=1, addr=0, write_data=55 -> read_data_out=69 before the edge, 55 after the edge.
REQ-027 write=0, read=0, addr=0 -> read_data_out=0; then read=1 -> last stored value at addr 0 (55 after REQ-026).
REQ-028 After writes to addr 0 and 6, assert rst asynchronously between edges -> mem[0] immediately reads 69, mem[6] reads 0; write=1 with rst=1 over several edges -> contents unchanged.
REQ-029 Sweep addr 0..7 writing value addr*3+1, then read back all 8 -> each matches; no aliasing between addresses.
